mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped character-output peripheral on the MIPS_CPU data bus; consumes CPU store cycles to its word addresses.
- Store writes queue a character in a small FIFO. A serializer drains the FIFO as 8N1 frames on a single tx line.
- Loads return a status word, so software can poll before writing.
- Hardware replacement for the simulation-only character sink used around the core.

Parameters:
- BASE_ADDR, 30'h0000_0000: word address of the TXDATA register. STATUS is at BASE_ADDR+1.
- FIFO_DEPTH, 8: FIFO entries. Must be a power of two, at least 2.
- CLKS_PER_BIT, 4: clk cycles per serial bit, at least 2. Sim default; synthesis overrides it.

Ports:
- clk, input, 1: single clock, rising-edge.
- rst_n, input, 1: asynchronous, active-low reset.
- data_bus, inout, 32: CPU data bus. Driven only during a selected read; high-Z otherwise.
- data_address, input, 30: CPU word address.
- data_cs, input, 1: bus cycle valid.
- data_rw, input, 1: 1 = write (store), 0 = read (load).
- tx, output, 1: serial line, idle high.
- tx_idle, output, 1: high when the FIFO is empty and the serializer is IDLE.

Behaviour:
- Interface: one clock (clk); asynchronous active-low reset (rst_n).
- Reset values:
  - tx=1, tx_idle=1, FIFO empty, overflow=0, serializer IDLE, data_bus high-Z.
  - Reset mid-frame aborts the frame immediately; tx goes high asynchronously.
- Address match rules:
  - sel_data: data_cs && data_address==BASE_ADDR.
  - sel_stat: data_cs && data_address==BASE_ADDR+1.
  - Other addresses are ignored entirely.
- Write (push):
  - sel_data && data_rw. The character is data_bus[15:8]; other bits are ignored. Value 0 is an ordinary character.
  - Sampled at the rising edge. The CPU holds each store for exactly one cycle, so one push per edge.
- Full FIFO:
  - A push while full (judged on pre-edge state, even if a pop occurs on the same edge) is dropped and sets the sticky overflow flag.
  - Writes to STATUS are ignored.
- Read (combinational, same cycle as cs):
  - sel_stat && !data_rw: drive the status word.
    - bit0 full, bit1 empty, bit2 busy (serializer not IDLE), bit3 overflow.
    - bits[7:4] = 0.
    - bits[15:8] = FIFO count, zero-extended.
    - bits[31:16] = 0.
  - sel_data && !data_rw: drive 32'h0.
  - A status read clears overflow at that rising edge. If an overflowing push occurs on the same edge, overflow is set (set wins).
- FIFO:
  - Synchronous, pointer wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
  - Simultaneous push and pop when not full: both take effect, count unchanged.
  - Pop of an empty FIFO never occurs.
- Serializer FSM states: IDLE, START, DATA, STOP. A bit counter runs 0..CLKS_PER_BIT-1 and a bit index 0..7.
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to START. tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go to START (gapless back-to-back). Otherwise go to IDLE.
- Latency and frame length:
  - A push at edge N into an empty FIFO with the serializer IDLE gives a pop and tx low from edge N+1.
  - Each frame is exactly 10*CLKS_PER_BIT cycles.
- tx is registered and glitch-free.
- tx_idle = empty && state==IDLE.

Decomposition:
- Package mmio_uart_pkg holds:
  - Register offsets (OFF_TXDATA=0, OFF_STATUS=1).
  - Status bit indices (ST_FULL, ST_EMPTY, ST_BUSY, ST_OVF).
  - Serializer state enum.
- Sub-module: uart_tx_fifo, a parameterized synchronous FIFO with push/pop/full/empty/count.
- Bus decode, the status mux and the serializer FSM stay in mmio_uart_tx.

Test Plan:
- Reset, then a store of 32'h0000_4100 to BASE_ADDR. Required:
  - tx falls one cycle after the store edge.
  - The frame decodes as 0x41 ('A'), 40 cycles long (CLKS_PER_BIT=4).
  - tx_idle returns to 1 after the stop bit.
- Three back-to-back stores of 'H','i','!'. Required:
  - Three contiguous frames with no idle cycles between STOP and the next START.
  - STATUS read mid-way shows busy=1 with the correct count.
- 10 consecutive stores while the serializer is busy (FIFO_DEPTH=8). Required:
  - STATUS shows full=1, count=8, overflow=1.
  - The next STATUS read shows overflow=0.
  - Exactly 9 characters are transmitted: one already popped plus 8 queued.
- Loads from BASE_ADDR and BASE_ADDR+1, plus a load to an unrelated address. Required:
  - BASE_ADDR returns 32'h0; BASE_ADDR+1 returns the correct status.
  - The unrelated address and cycles with data_cs=0 leave data_bus high-Z.
- Assert rst_n low during the DATA state of a frame. Required:
  - tx=1 immediately without waiting for a clock.
  - Status reads empty=1, count=0.
  - No partial frame resumes after release.

Source files
------------

// File: rtl/mmio_uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// status bit positions and the serializer state encoding.
package mmio_uart_pkg;
  localparam int OFF_TXDATA = 0;
  localparam int OFF_STATUS = 1;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_e;
endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; pushes while full and pops while
// empty are ignored so the caller only has to present intent.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// Character-output peripheral on the CPU data bus: TXDATA stores feed a FIFO,
// a serializer drains it as 8N1 frames, STATUS loads report FIFO/line state.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [29:0] BASE_ADDR    = 30'h0000_0000,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  inout  wire  [31:0] data_bus,
  input  logic [29:0] data_address,
  input  logic        data_cs,
  input  logic        data_rw,
  output logic        tx,
  output logic        tx_idle
);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int BCW = $clog2(CLKS_PER_BIT);

  logic          sel_data, sel_stat, push, stat_rd, bus_drv;
  logic [31:0]   rd_data, status;
  logic          overflow;
  logic          fifo_full, fifo_empty, pop;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          unused_bus;

  ser_state_e    state, nxt;
  logic [BCW-1:0] bit_cnt, cnt_nxt;
  logic [2:0]    bit_idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_q, tx_nxt, last_clk;

  assign sel_data   = data_cs && (data_address == BASE_ADDR + 30'(OFF_TXDATA));
  assign sel_stat   = data_cs && (data_address == BASE_ADDR + 30'(OFF_STATUS));
  assign push       = sel_data && data_rw;
  assign stat_rd    = sel_stat && !data_rw;
  assign bus_drv    = stat_rd || (sel_data && !data_rw);
  assign unused_bus = ^{data_bus[31:16], data_bus[7:0]};

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (data_bus[15:8]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Full is judged before the edge, so a same-edge pop never rescues the push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 overflow <= 1'b0;
    else if (push && fifo_full) overflow <= 1'b1;
    else if (stat_rd)           overflow <= 1'b0;
  end

  always_comb begin
    status          = '0;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_BUSY]  = (state != IDLE);
    status[ST_OVF]   = overflow;
    status[15:8]     = 8'(fifo_count);
  end

  assign rd_data  = stat_rd ? status : 32'h0;
  assign data_bus = bus_drv ? rd_data : 32'hzzzz_zzzz;

  assign last_clk = (bit_cnt == BCW'(CLKS_PER_BIT - 1));

  // tx_nxt is the line level for the state being entered, so tx is a clean flop.
  always_comb begin
    nxt       = state;
    cnt_nxt   = bit_cnt + BCW'(1);
    idx_nxt   = bit_idx;
    shift_nxt = shift;
    tx_nxt    = 1'b1;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_dout;
          nxt       = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        tx_nxt = 1'b0;
        if (last_clk) begin
          cnt_nxt = '0;
          idx_nxt = '0;
          nxt     = DATA;
          tx_nxt  = shift[0];
        end
      end
      DATA: begin
        tx_nxt = shift[0];
        if (last_clk) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            nxt    = STOP;
            tx_nxt = 1'b1;
          end else begin
            idx_nxt   = bit_idx + 3'd1;
            shift_nxt = shift >> 1;
            tx_nxt    = shift[1];
          end
        end
      end
      STOP: begin
        if (last_clk) begin
          cnt_nxt = '0;
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_nxt = fifo_dout;
            nxt       = START;
            tx_nxt    = 1'b0;
          end else begin
            nxt = IDLE;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= nxt;
      bit_cnt <= cnt_nxt;
      bit_idx <= idx_nxt;
      shift   <= shift_nxt;
      tx_q    <= tx_nxt;
    end
  end

  assign tx      = tx_q;
  assign tx_idle = fifo_empty && (state == IDLE);
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: frame decode from a per-cycle tx log,
// status word checks, overflow, bus release and mid-frame reset.
module tb_mmio_uart_tx;
  localparam logic [29:0] BASE = 30'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  wire  [31:0] data_bus;
  logic [29:0] data_address;
  logic        data_cs, data_rw;
  logic        tx, tx_idle;
  logic        tb_drv;
  logic [31:0] tb_bus;

  int errors = 0;
  int checks = 0;

  logic rec = 1'b0;
  logic txlog[$];
  logic idlelog[$];

  assign data_bus = tb_drv ? tb_bus : 32'hzzzz_zzzz;

  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .CLKS_PER_BIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_bus     (data_bus),
    .data_address (data_address),
    .data_cs      (data_cs),
    .data_rw      (data_rw),
    .tx           (tx),
    .tx_idle      (tx_idle)
  );

  always #5 clk = ~clk;

  // Log index k holds the line state just after the k-th edge since logging began.
  always @(posedge clk) begin
    #3;
    if (rec) begin
      txlog.push_back(tx);
      idlelog.push_back(tx_idle);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [29:0] a, input logic [7:0] ch);
    data_address = a;
    data_cs = 1'b1;
    data_rw = 1'b1;
    tb_drv  = 1'b1;
    tb_bus  = {16'hDEAD, ch, 8'hBE};
    tick(1);
    data_cs = 1'b0;
    tb_drv  = 1'b0;
  endtask

  task automatic load(input logic [29:0] a, output logic [31:0] v);
    data_address = a;
    data_cs = 1'b1;
    data_rw = 1'b0;
    tb_drv  = 1'b0;
    #2 v = data_bus;
    tick(1);
    data_cs = 1'b0;
  endtask

  // The bench holds the bus at zero; any DUT drive shows up as a non-zero or unknown value.
  task automatic probe(input logic [29:0] a, input logic cs, output logic [31:0] v);
    data_address = a;
    data_cs = cs;
    data_rw = 1'b0;
    tb_drv  = 1'b1;
    tb_bus  = 32'h0;
    #2 v = data_bus;
    tick(1);
    data_cs = 1'b0;
    tb_drv  = 1'b0;
  endtask

  task automatic log_start();
    txlog.delete();
    idlelog.delete();
    rec = 1'b1;
  endtask

  // Returns {ok, char} for an 8N1 frame of 4 clocks per bit starting at log index b.
  function automatic logic [8:0] decode(input int b);
    logic       ok = 1'b1;
    logic [7:0] ch = '0;
    for (int i = 0; i < 4; i++) if (txlog[b+i] !== 1'b0) ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ch[k] = txlog[b+4+4*k];
      for (int j = 1; j < 4; j++) if (txlog[b+4+4*k+j] !== ch[k]) ok = 1'b0;
    end
    for (int i = 36; i < 40; i++) if (txlog[b+i] !== 1'b1) ok = 1'b0;
    return {ok, ch};
  endfunction

  initial begin
    logic [31:0] v;
    logic [7:0]  ovf_chars [10];
    int          zeros;

    rst_n = 1'b1;
    data_address = '0;
    data_cs = 1'b0;
    data_rw = 1'b0;
    tb_drv  = 1'b0;
    tb_bus  = '0;
    #1 rst_n = 1'b0;
    tick(2);
    check("reset tx", {31'h0, tx}, 32'h1);
    check("reset tx_idle", {31'h0, tx_idle}, 32'h1);
    load(BASE + 30'd1, v);
    check("reset status", v, 32'h0000_0002);
    @(negedge clk) rst_n = 1'b1;
    tick(2);

    // Single 'A': tx falls one cycle after the store edge (log index 1).
    log_start();
    store(BASE, 8'h41);
    tick(48);
    check("A line high at store edge", {31'h0, txlog[1]}, 32'h1);
    check("A start one cycle later", {31'h0, txlog[2]}, 32'h0);
    check("A frame", {23'h0, decode(2)}, {23'h0, 1'b1, 8'h41});
    check("A idle low in stop", {31'h0, idlelog[41]}, 32'h0);
    check("A idle after stop", {31'h0, idlelog[42]}, 32'h1);
    check("A line high after stop", {31'h0, txlog[42]}, 32'h1);

    // Back-to-back 'H','i','!': frames at 2, 42, 82 with no gap.
    log_start();
    store(BASE, 8'h48);
    store(BASE, 8'h69);
    store(BASE, 8'h21);
    load(BASE + 30'd1, v);
    check("Hi! status early", v, 32'h0000_0204);
    tick(45);
    load(BASE + 30'd1, v);
    check("Hi! status mid", v, 32'h0000_0104);
    tick(90);
    check("H frame", {23'h0, decode(2)}, {23'h0, 1'b1, 8'h48});
    check("i frame", {23'h0, decode(42)}, {23'h0, 1'b1, 8'h69});
    check("! frame", {23'h0, decode(82)}, {23'h0, 1'b1, 8'h21});
    check("Hi! idle low at end of stop", {31'h0, idlelog[121]}, 32'h0);
    check("Hi! idle after last stop", {31'h0, idlelog[122]}, 32'h1);

    // Ten stores into depth 8 while the first is popped: nine survive.
    for (int k = 0; k < 10; k++) ovf_chars[k] = (k == 0) ? 8'h00 : 8'hA0 + 8'(k);
    log_start();
    for (int k = 0; k < 10; k++) store(BASE, ovf_chars[k]);
    load(BASE + 30'd1, v);
    check("ovf status full", v, 32'h0000_080D);
    load(BASE + 30'd1, v);
    check("ovf cleared by read", v, 32'h0000_0805);
    tick(370);
    for (int k = 0; k < 9; k++)
      check($sformatf("ovf frame %0d", k), {23'h0, decode(2 + 40*k)}, {23'h0, 1'b1, ovf_chars[k]});
    check("ovf line high after 9 frames", {31'h0, txlog[362]}, 32'h1);
    check("ovf idle after 9 frames", {31'h0, idlelog[362]}, 32'h1);
    check("ovf idle low in 9th stop", {31'h0, idlelog[361]}, 32'h0);

    // Loads, ignored stores and bus release.
    load(BASE, v);
    check("TXDATA load", v, 32'h0);
    load(BASE + 30'd1, v);
    check("STATUS load idle", v, 32'h0000_0002);
    probe(BASE + 30'd2, 1'b1, v);
    check("unrelated load leaves bus", v, 32'h0);
    probe(BASE + 30'd1, 1'b0, v);
    check("cs low leaves bus", v, 32'h0);
    store(BASE + 30'd1, 8'h77);
    store(BASE + 30'd5, 8'h66);
    tick(2);
    check("ignored stores tx_idle", {31'h0, tx_idle}, 32'h1);
    load(BASE + 30'd1, v);
    check("ignored stores status", v, 32'h0000_0002);

    // Reset during DATA bit 0 of 0x5A with one more char queued.
    store(BASE, 8'h5A);
    store(BASE, 8'h51);
    tick(5);
    check("pre-reset tx data bit0", {31'h0, tx}, 32'h0);
    #1 rst_n = 1'b0;
    #1 check("async reset tx", {31'h0, tx}, 32'h1);
    data_address = BASE + 30'd1;
    data_cs = 1'b1;
    data_rw = 1'b0;
    #1 check("status in reset", data_bus, 32'h0000_0002);
    data_cs = 1'b0;
    tick(2);
    @(negedge clk) rst_n = 1'b1;
    tick(1);
    log_start();
    tick(60);
    zeros = 0;
    foreach (txlog[i]) if (txlog[i] !== 1'b1) zeros++;
    check("no frame after reset", 32'(zeros), 32'h0);
    check("idle after reset", {31'h0, tx_idle}, 32'h1);
    rec = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
